// File: rtl/axi_ic_pkg.sv
// Shared definitions for the 2x2 AXI interconnect controllers (write and read paths).
package axi_ic_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_DATA     = 3'd2;
  localparam logic [2:0] ST_RESP     = 3'd3;
  localparam logic [2:0] ST_ERR_ADDR = 3'd4;
  localparam logic [2:0] ST_ERR_DATA = 3'd5;
  localparam logic [2:0] ST_ERR_RESP = 3'd6;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    ADDR     = ST_ADDR,
    DATA     = ST_DATA,
    RESP     = ST_RESP,
    ERR_ADDR = ST_ERR_ADDR,
    ERR_DATA = ST_ERR_DATA,
    ERR_RESP = ST_ERR_RESP
  } ctrl_state_e;

  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic MASTER_0 = 1'b0;
  localparam logic MASTER_1 = 1'b1;
  localparam logic SLAVE_0  = 1'b0;
  localparam logic SLAVE_1  = 1'b1;

endpackage

// File: rtl/axi_addr_decode.sv
// Combinational address-window decode for the two register-file slaves; S0 wins on overlap.
module axi_addr_decode
  import axi_ic_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] s0_lo,
  input  logic [ADDR_W-1:0] s0_hi,
  input  logic [ADDR_W-1:0] s1_lo,
  input  logic [ADDR_W-1:0] s1_hi,
  output logic              hit_s0,
  output logic              hit_s1,
  output logic              miss
);

  logic in_s0, in_s1;

  // An inverted window (lo > hi) is treated as disabled rather than wrapping.
  assign in_s0 = (s0_lo <= s0_hi) && (addr >= s0_lo) && (addr <= s0_hi);
  assign in_s1 = (s1_lo <= s1_hi) && (addr >= s1_lo) && (addr <= s1_hi);

  assign hit_s0 = in_s0;
  assign hit_s1 = in_s1 && !in_s0;
  assign miss   = !in_s0 && !in_s1;

endmodule

// File: rtl/axi_write_arbiter.sv
// Write-path controller: round-robin AW arbitration, slave decode, and AW/W/B sequencing
// of one transaction at a time; unmapped addresses are sunk locally and answered with DECERR.
module axi_write_arbiter
  import axi_ic_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] DECERR = RESP_DECERR
) (
  input  logic              clkk,
  input  logic              resett,
  input  logic [ADDR_W-1:0] slave0_addr1,
  input  logic [ADDR_W-1:0] slave0_addr2,
  input  logic [ADDR_W-1:0] slave1_addr1,
  input  logic [ADDR_W-1:0] slave1_addr2,
  input  logic [ADDR_W-1:0] M0_AWADDR,
  input  logic [ADDR_W-1:0] M1_AWADDR,
  input  logic              M0_AWVALID,
  input  logic              M1_AWVALID,
  input  logic              M0_WVALID,
  input  logic              M1_WVALID,
  input  logic              M0_WLAST,
  input  logic              M1_WLAST,
  input  logic              M0_BREADY,
  input  logic              M1_BREADY,
  input  logic              S0_AWREADY,
  input  logic              S1_AWREADY,
  input  logic              S0_WREADY,
  input  logic              S1_WREADY,
  input  logic              S0_BVALID,
  input  logic              S1_BVALID,
  output logic              S0_AWVALID,
  output logic              S1_AWVALID,
  output logic              S0_WVALID,
  output logic              S1_WVALID,
  output logic              S0_BREADY,
  output logic              S1_BREADY,
  output logic              M0_AWREADY,
  output logic              M1_AWREADY,
  output logic              M0_WREADY,
  output logic              M1_WREADY,
  output logic              M0_BVALID,
  output logic              M1_BVALID,
  output logic              select_master_write,
  output logic              select_slave_write,
  output logic              resp_override,
  output logic              busy
);

  ctrl_state_e       state, next_state;
  logic              grant, target, rr_ptr;
  logic              any_req, next_grant;
  logic [ADDR_W-1:0] req_addr;
  logic              hit_s0, hit_s1, miss;

  logic mg_awvalid, mg_wvalid, mg_wlast, mg_bready;
  logic sx_awready, sx_wready, sx_bvalid;
  logic s_awvalid, s_wvalid, s_bready;
  logic m_awready, m_wready, m_bvalid;

  // Lone requester wins outright; on contention rr_ptr picks the master.
  assign any_req    = M0_AWVALID || M1_AWVALID;
  assign next_grant = M1_AWVALID && (!M0_AWVALID || rr_ptr);
  assign req_addr   = next_grant ? M1_AWADDR : M0_AWADDR;

  axi_addr_decode #(.ADDR_W(ADDR_W)) u_decode (
    .addr   (req_addr),
    .s0_lo  (slave0_addr1),
    .s0_hi  (slave0_addr2),
    .s1_lo  (slave1_addr1),
    .s1_hi  (slave1_addr2),
    .hit_s0 (hit_s0),
    .hit_s1 (hit_s1),
    .miss   (miss)
  );

  assign mg_awvalid = (grant == MASTER_1) ? M1_AWVALID : M0_AWVALID;
  assign mg_wvalid  = (grant == MASTER_1) ? M1_WVALID  : M0_WVALID;
  assign mg_wlast   = (grant == MASTER_1) ? M1_WLAST   : M0_WLAST;
  assign mg_bready  = (grant == MASTER_1) ? M1_BREADY  : M0_BREADY;
  assign sx_awready = (target == SLAVE_1) ? S1_AWREADY : S0_AWREADY;
  assign sx_wready  = (target == SLAVE_1) ? S1_WREADY  : S0_WREADY;
  assign sx_bvalid  = (target == SLAVE_1) ? S1_BVALID  : S0_BVALID;

  always_ff @(posedge clkk or posedge resett) begin
    if (resett) begin
      state  <= IDLE;
      grant  <= MASTER_0;
      target <= SLAVE_0;
      rr_ptr <= MASTER_0;
    end else begin
      state <= next_state;
      if (state == IDLE && any_req) begin
        grant  <= next_grant;
        target <= hit_s1 ? SLAVE_1 : SLAVE_0;
      end
      if (state == RESP && sx_bvalid && mg_bready)
        rr_ptr <= ~grant;
      else if (state == ERR_RESP && mg_bready)
        rr_ptr <= ~rr_ptr;
    end
  end

  // Within a state the handshake paths are pure wires, so no cycles are added per beat.
  always_comb begin
    next_state    = state;
    s_awvalid     = 1'b0;
    s_wvalid      = 1'b0;
    s_bready      = 1'b0;
    m_awready     = 1'b0;
    m_wready      = 1'b0;
    m_bvalid      = 1'b0;
    resp_override = 1'b0;
    case (state)
      IDLE:
        if (any_req) next_state = miss ? ERR_ADDR : ADDR;
      ADDR: begin
        s_awvalid = mg_awvalid;
        m_awready = sx_awready;
        if (mg_awvalid && sx_awready) next_state = DATA;
      end
      DATA: begin
        s_wvalid = mg_wvalid;
        m_wready = sx_wready;
        if (mg_wvalid && sx_wready && mg_wlast) next_state = RESP;
      end
      RESP: begin
        m_bvalid = sx_bvalid;
        s_bready = mg_bready;
        if (sx_bvalid && mg_bready) next_state = IDLE;
      end
      ERR_ADDR: begin
        m_awready  = 1'b1;
        next_state = ERR_DATA;
      end
      ERR_DATA: begin
        m_wready = 1'b1;
        if (mg_wvalid && mg_wlast) next_state = ERR_RESP;
      end
      ERR_RESP: begin
        m_bvalid      = 1'b1;
        resp_override = 1'b1;
        if (mg_bready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign S0_AWVALID = s_awvalid && (target == SLAVE_0);
  assign S1_AWVALID = s_awvalid && (target == SLAVE_1);
  assign S0_WVALID  = s_wvalid  && (target == SLAVE_0);
  assign S1_WVALID  = s_wvalid  && (target == SLAVE_1);
  assign S0_BREADY  = s_bready  && (target == SLAVE_0);
  assign S1_BREADY  = s_bready  && (target == SLAVE_1);
  assign M0_AWREADY = m_awready && (grant == MASTER_0);
  assign M1_AWREADY = m_awready && (grant == MASTER_1);
  assign M0_WREADY  = m_wready  && (grant == MASTER_0);
  assign M1_WREADY  = m_wready  && (grant == MASTER_1);
  assign M0_BVALID  = m_bvalid  && (grant == MASTER_0);
  assign M1_BVALID  = m_bvalid  && (grant == MASTER_1);

  assign select_master_write = grant;
  assign select_slave_write  = target;
  assign busy                = (state != IDLE);

endmodule
